nanov_periph_hub: RTL and testbench
===================================

Name: nanov_periph_hub

Overview:
- Memory-mapped peripheral hub for nanoV; the next generation of the top-level GPIO/UART decode.
- Sits between the CPU's store/load strobes and the chip pins. Decodes a latched address and provides:
  - a parametrised-width GPIO port
  - full-duplex 8N1 UART with TX and RX FIFOs
  - a status register with sticky error flags
  - a free-running 32-bit cycle timer

Parameters:
- BASE_ADDR, 32'h1000_0000, peripheral base address. GPIO at +0x0000, UART data at +0x1000, UART status at +0x1004, timer at +0x2000.
- GPIO_W, 8, GPIO in/out width (1..32).
- CLK_HZ, 12_000_000, clock frequency.
- BIT_RATE, 115_200, UART bit rate. DIV = CLK_HZ/BIT_RATE (integer division; 104 at defaults).
- TX_DEPTH, 4, TX FIFO entries (power of 2, >=2).
- RX_DEPTH, 4, RX FIFO entries (power of 2, >=2).
- REVERSE_WDATA, 1, when 1, wdata is bit-reversed (bit i <- bit 31-i) before use as a data value. Address compare always uses wdata un-reversed.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- addr_strobe  in  1  wdata holds a load/store address this cycle.
- data_strobe  in  1  wdata holds store data this cycle.
- data_rd  in  1  CPU has consumed rdata this cycle (load completion).
- wdata  in  32  CPU address/store data.
- rdata  out  32  read data for the currently selected register.
- gpio_in  in  GPIO_W  GPIO inputs.
- gpio_out  out  GPIO_W  GPIO output register.
- uart_txd  out  1  UART transmit line, idle high.
- uart_rxd  in  1  UART receive line, asynchronous.
- irq  out  1  high while the RX FIFO is non-empty or any sticky error is set.

Behaviour:
- Reset (rst=1 at posedge):
  - gpio_out=0, uart_txd=1, all selects cleared, FIFOs empty, sticky flags 0, timer=0.
  - TX/RX engines go idle immediately; any in-flight frame is aborted.
  - rdata=0 and irq=0 after reset.
- Decode:
  - On addr_strobe, the one-hot select {gpio, udata, ustat, timer} is registered from an exact wdata match.
  - A non-matching address clears all selects.
  - The select holds until the next addr_strobe.
- rdata, combinational from the selects, upper bits zero:
  - gpio: gpio_in
  - udata: RX FIFO head byte (0 if empty)
  - ustat: {27'b0, frame_err, overrun, tx_idle, rx_valid, tx_full}
  - timer: counter value
  - none: 0
- Stores (data_strobe, value D = wdata after optional reversal):
  - gpio: gpio_out <= D[GPIO_W-1:0].
  - udata: push D[7:0] into the TX FIFO. If full, the byte is dropped, unless the TX engine pops in the same cycle, in which case the push is accepted.
  - timer: counter <= D. The load takes priority over the increment.
  - ustat: ignored.
- Reads (data_rd):
  - udata with RX FIFO non-empty: pop one entry. Reading while empty does nothing.
  - ustat: clears overrun and frame_err after the read.
  - An error event in the same cycle as the clear wins; the flag stays set.
- Timer: +1 every cycle, wraps 0xFFFF_FFFF -> 0.
- TX engine, states IDLE/START/DATA/STOP:
  - IDLE with FIFO non-empty: pop, go to START.
  - Each bit is held DIV cycles: START 0, DATA 8 bits LSB first, STOP 1.
  - After STOP, return to IDLE and start the next frame back-to-back (no extra idle cycle).
  - tx_idle = IDLE && FIFO empty. tx_full = TX FIFO count == TX_DEPTH.
- RX engine, states IDLE/START/DATA/STOP:
  - uart_rxd passes through a 2-flop synchroniser.
  - IDLE: a synchronised 1->0 edge enters START.
  - At DIV/2 cycles, if the line is high, it is a false start: go to IDLE. Otherwise sample 8 data bits at DIV intervals (mid-bit), then the stop bit.
  - Stop=1: push the byte. If the RX FIFO is full, drop the byte and set overrun. A same-cycle pop frees space and the push succeeds.
  - Stop=0: drop the byte and set frame_err.
  - Return to IDLE after the stop sample.
  - rx_valid = RX FIFO non-empty.
- addr_strobe and data_strobe in the same cycle: the address update applies; the data uses the old select.

Test Plan:
- Reset, then addr 0x1000_0000; store 0x000000A5 reversed (wdata=0xA500_0000) -> gpio_out=0xA5. Drive gpio_in=0x3C -> rdata=0x0000_003C.
- Addr 0x1000_1000, store bytes 0x55, 0x0F back-to-back -> txd shows start, 10101010 (LSB first), stop, each bit 104 cycles. The second frame starts on the next cycle after the first stop bit; tx_idle=1 only after both frames.
- Fill the TX FIFO with 5 stores while the engine is busy on the first byte -> tx_full=1 after the FIFO fills; the fifth byte is dropped; exactly 5 frames total... (first popped + 4 queued); the later write is absent from txd.
- Drive an RX frame 0xC3 at 115200 -> rx_valid=1, irq=1, udata read returns 0xC3; after data_rd, rx_valid=0 and irq=0.
- Send 5 RX frames without reading -> overrun=1; reads return the first 4 bytes. Status read clears overrun. A frame with stop=0 -> frame_err=1, no push. A 20-cycle low glitch -> no byte, no flag.
- Store 0xFFFF_FFFE to the timer (non-reversed value) -> reads 0xFFFF_FFFF next cycle, then 0x0. Assert rst mid-TX-frame -> txd=1 the next cycle and the FIFO is empty.

Source files
------------

// File: rtl/nanov_periph_hub.sv
// nanov_periph_hub: memory-mapped GPIO, 8N1 UART with FIFOs, status flags and cycle timer for nanoV
module nanov_periph_hub #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int GPIO_W = 8,
  parameter int CLK_HZ = 12_000_000,
  parameter int BIT_RATE = 115_200,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter bit REVERSE_WDATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_strobe,
  input  logic              data_strobe,
  input  logic              data_rd,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              uart_txd,
  input  logic              uart_rxd,
  output logic              irq
);
  localparam int DIV = CLK_HZ / BIT_RATE;
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;
  logic [31:0] d;
  logic sel_gpio, sel_udata, sel_ustat, sel_timer;
  logic [31:0] timer;
  logic overrun, frame_err;
  always_comb begin
    d = '0;
    for (int i = 0; i < 32; i++) d[i] = REVERSE_WDATA ? wdata[31-i] : wdata[i];
  end
  // Address compare uses raw wdata; only store data is reversed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_gpio <= 1'b0;
      sel_udata <= 1'b0;
      sel_ustat <= 1'b0;
      sel_timer <= 1'b0;
    end else if (addr_strobe) begin
      sel_gpio <= wdata == BASE_ADDR;
      sel_udata <= wdata == BASE_ADDR + 32'h1000;
      sel_ustat <= wdata == BASE_ADDR + 32'h1004;
      sel_timer <= wdata == BASE_ADDR + 32'h2000;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) gpio_out <= '0;
    else if (data_strobe && sel_gpio) gpio_out <= d[GPIO_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) timer <= '0;
    else if (data_strobe && sel_timer) timer <= d;
    else timer <= timer + 32'd1;
  end
  uart_st_t tx_st;
  logic [CW-1:0] tx_baud;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic [7:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [TAW:0] tx_cnt;
  logic tx_full, tx_empty, tx_push, tx_pop, tx_idle;
  assign tx_full = tx_cnt == (TAW+1)'(TX_DEPTH);
  assign tx_empty = tx_cnt == '0;
  // Popping at the end of a stop bit lets the next frame follow with no idle gap.
  assign tx_pop = !tx_empty && (tx_st == IDLE || (tx_st == STOP && tx_baud == DIV_M1));
  assign tx_push = data_strobe && sel_udata && (!tx_full || tx_pop);
  assign tx_idle = tx_st == IDLE && tx_empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_cnt <= '0;
    end else begin
      tx_wp <= tx_wp + TAW'(tx_push);
      tx_rp <= tx_rp + TAW'(tx_pop);
      tx_cnt <= tx_cnt + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
    end
  end
  always_ff @(posedge clk) if (tx_push) tx_mem[tx_wp] <= d[7:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= IDLE;
      tx_baud <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      uart_txd <= 1'b1;
    end else if (tx_pop) begin
      tx_st <= START;
      tx_baud <= '0;
      tx_sh <= tx_mem[tx_rp];
      uart_txd <= 1'b0;
    end else if (tx_st != IDLE) begin
      if (tx_baud != DIV_M1) tx_baud <= tx_baud + CW'(1);
      else begin
        tx_baud <= '0;
        case (tx_st)
          START: begin
            tx_st <= DATA;
            tx_bit <= '0;
            uart_txd <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
          end
          DATA: begin
            if (tx_bit == 3'd7) begin
              tx_st <= STOP;
              uart_txd <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              uart_txd <= tx_sh[0];
              tx_sh <= tx_sh >> 1;
            end
          end
          default: begin
            tx_st <= IDLE;
            uart_txd <= 1'b1;
          end
        endcase
      end
    end
  end
  uart_st_t rx_st;
  logic [CW-1:0] rx_baud;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic [2:0] rx_sync;
  logic [7:0] rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [RAW:0] rx_cnt;
  logic rxs, rx_fall, rx_done, rx_ev, rx_full, rx_empty, rx_push, rx_pop, st_clr;
  // rx_sync[1] is the synchronised line; rx_sync[2] is its previous value for edge detect.
  assign rxs = rx_sync[1];
  assign rx_fall = rx_sync[2] && !rx_sync[1];
  assign rx_done = rx_st == STOP && rx_baud == DIV_M1;
  assign rx_ev = rx_done && rxs;
  assign rx_full = rx_cnt == (RAW+1)'(RX_DEPTH);
  assign rx_empty = rx_cnt == '0;
  assign rx_pop = data_rd && sel_udata && !rx_empty;
  assign rx_push = rx_ev && (!rx_full || rx_pop);
  assign st_clr = data_rd && sel_ustat;
  always_ff @(posedge clk) begin
    if (rst) rx_sync <= 3'b111;
    else rx_sync <= {rx_sync[1:0], uart_rxd};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st <= IDLE;
      rx_baud <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      case (rx_st)
        IDLE: if (rx_fall) begin
          rx_st <= START;
          rx_baud <= '0;
        end
        START: begin
          if (rx_baud != HALF_M1) rx_baud <= rx_baud + CW'(1);
          else begin
            rx_baud <= '0;
            rx_bit <= '0;
            rx_st <= rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (rx_baud != DIV_M1) rx_baud <= rx_baud + CW'(1);
          else begin
            rx_baud <= '0;
            rx_sh <= {rxs, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            rx_st <= rx_bit == 3'd7 ? STOP : DATA;
          end
        end
        default: begin
          if (rx_baud != DIV_M1) rx_baud <= rx_baud + CW'(1);
          else begin
            rx_baud <= '0;
            rx_st <= IDLE;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_cnt <= '0;
    end else begin
      rx_wp <= rx_wp + RAW'(rx_push);
      rx_rp <= rx_rp + RAW'(rx_pop);
      rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
    end
  end
  always_ff @(posedge clk) if (rx_push) rx_mem[rx_wp] <= rx_sh;
  // A new error event outranks a status-read clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun <= (rx_ev && !rx_push) || (overrun && !st_clr);
      frame_err <= (rx_done && !rxs) || (frame_err && !st_clr);
    end
  end
  always_comb begin
    rdata = sel_gpio ? 32'(gpio_in) :
            sel_udata ? {24'b0, rx_empty ? 8'h00 : rx_mem[rx_rp]} :
            sel_ustat ? {27'b0, frame_err, overrun, tx_idle, !rx_empty, tx_full} :
            sel_timer ? timer : 32'h0;
  end
  assign irq = !rx_empty || overrun || frame_err;
endmodule

// File: tb/tb_nanov_periph_hub.sv
// tb_nanov_periph_hub: scenario bench for the nanoV peripheral hub with TX/RX scoreboards
module tb_nanov_periph_hub;
  localparam int DIV = 12_000_000 / 115_200;
  localparam logic [31:0] BASE = 32'h1000_0000;
  logic clk = 1'b0, rst = 1'b1, addr_strobe = 1'b0, data_strobe = 1'b0, data_rd = 1'b0;
  logic [31:0] wdata = '0, rdata;
  logic [7:0] gpio_in = '0, gpio_out;
  logic uart_txd, uart_rxd = 1'b1, irq;
  int total = 0, bad = 0, cyc = 0;
  logic [8:0] got_tx[$];
  int got_t[$];
  logic [7:0] exp_tx[$], exp_rx[$];

  nanov_periph_hub dut (
    .clk(clk), .rst(rst), .addr_strobe(addr_strobe), .data_strobe(data_strobe),
    .data_rd(data_rd), .wdata(wdata), .rdata(rdata), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .uart_txd(uart_txd), .uart_rxd(uart_rxd), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decodes frames on uart_txd by mid-bit sampling; records {stop, byte} and start cycle.
  initial begin : tx_mon
    logic prev;
    logic [7:0] b;
    logic s;
    int t0;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !uart_txd) begin
        t0 = cyc;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (DIV) @(negedge clk);
        s = uart_txd;
        got_tx.push_back({s, b});
        got_t.push_back(t0);
      end
      prev = uart_txd;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic set_addr(input logic [31:0] a);
    addr_strobe = 1'b1;
    wdata = a;
    @(negedge clk);
    addr_strobe = 1'b0;
  endtask

  task automatic store(input logic [31:0] v);
    data_strobe = 1'b1;
    wdata = rev32(v);
    @(negedge clk);
    data_strobe = 1'b0;
  endtask

  task automatic read(output logic [31:0] v);
    v = rdata;
    data_rd = 1'b1;
    @(negedge clk);
    data_rd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (got_tx.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (got_tx.size() < n) begin
      bad++;
      $display("FAIL wait_tx: frames seen %0d, need %0d", got_tx.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b exp 1", uart_txd); end
    total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL reset_gpio: got %h exp 00", gpio_out); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b exp 0", irq); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gpio();
    set_addr(BASE);
    store(32'hA5);
    total++; if (gpio_out !== 8'hA5) begin bad++; $display("FAIL gpio_out: got %h exp a5", gpio_out); end
    gpio_in = 8'h3C;
    @(negedge clk);
    total++; if (rdata !== 32'h3C) begin bad++; $display("FAIL gpio_in: got %h exp 3c", rdata); end
    set_addr(BASE + 32'h4);
    store(32'h12);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL nomatch_rdata: got %h exp 0", rdata); end
    total++; if (gpio_out !== 8'hA5) begin bad++; $display("FAIL nomatch_store: got %h exp a5", gpio_out); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] g;
    logic [7:0] e;
    got_tx.delete(); got_t.delete();
    set_addr(BASE + 32'h1000);
    exp_tx.push_back(8'h55); store(32'h55);
    exp_tx.push_back(8'h0F); store(32'h0F);
    set_addr(BASE + 32'h1004);
    total++; if (rdata[2] !== 1'b0) begin bad++; $display("FAIL b2b_busy: tx_idle got %b exp 0", rdata[2]); end
    wait_tx(2, 25 * DIV);
    total++; if (rdata[2] !== 1'b0) begin bad++; $display("FAIL b2b_in_stop: tx_idle got %b exp 0", rdata[2]); end
    total++;
    if (got_t.size() < 2 || got_t[1] - got_t[0] != 10 * DIV) begin
      bad++;
      $display("FAIL b2b_gap: frame spacing got %0d exp %0d", got_t.size() < 2 ? -1 : got_t[1] - got_t[0], 10 * DIV);
    end
    while (exp_tx.size() > 0 && got_tx.size() > 0) begin
      g = got_tx.pop_front(); e = exp_tx.pop_front();
      total++; if (g !== {1'b1, e}) begin bad++; $display("FAIL b2b_byte: got %h exp %h", g, {1'b1, e}); end
    end
    exp_tx.delete();
    repeat (DIV) @(negedge clk);
    total++; if (rdata !== 32'h4) begin bad++; $display("FAIL b2b_idle: status got %h exp 4", rdata); end
  endtask

  task automatic test_tx_full();
    logic [8:0] g;
    logic [7:0] e;
    got_tx.delete(); got_t.delete();
    set_addr(BASE + 32'h1000);
    exp_tx.push_back(8'hA1); store(32'hA1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_tx.push_back(8'hA2 + 8'(i));
      store(32'hA2 + 32'(i));
    end
    set_addr(BASE + 32'h1004);
    total++; if (rdata !== 32'h1) begin bad++; $display("FAIL full_status: got %h exp 1", rdata); end
    wait_tx(5, 60 * DIV);
    while (exp_tx.size() > 0 && got_tx.size() > 0) begin
      g = got_tx.pop_front(); e = exp_tx.pop_front();
      total++; if (g !== {1'b1, e}) begin bad++; $display("FAIL full_byte: got %h exp %h", g, {1'b1, e}); end
    end
    exp_tx.delete();
    repeat (12 * DIV) @(negedge clk);
    total++; if (got_tx.size() != 0) begin bad++; $display("FAIL full_drop: extra frames got %0d exp 0", got_tx.size()); end
    total++; if (rdata !== 32'h4) begin bad++; $display("FAIL full_idle: status got %h exp 4", rdata); end
  endtask

  task automatic test_rx_single();
    logic [31:0] v;
    set_addr(BASE + 32'h1000);
    exp_rx.push_back(8'hC3);
    send_rx(8'hC3, 1'b1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rx_irq: got %b exp 1", irq); end
    set_addr(BASE + 32'h1004);
    total++; if (rdata !== 32'h6) begin bad++; $display("FAIL rx_status: got %h exp 6", rdata); end
    set_addr(BASE + 32'h1000);
    read(v);
    total++; if (v !== {24'b0, exp_rx.pop_front()}) begin bad++; $display("FAIL rx_byte: got %h exp c3", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rx_irq_clr: got %b exp 0", irq); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rx_empty: got %h exp 0", rdata); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] v;
    logic [7:0] e;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_rx.push_back(8'h11 * 8'(i + 1));
      send_rx(8'h11 * 8'(i + 1), 1'b1);
    end
    set_addr(BASE + 32'h1004);
    total++; if (rdata !== 32'hE) begin bad++; $display("FAIL ovr_status: got %h exp e", rdata); end
    read(v);
    total++; if (rdata !== 32'h6) begin bad++; $display("FAIL ovr_clear: got %h exp 6", rdata); end
    set_addr(BASE + 32'h1000);
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      read(v);
      total++; if (v !== {24'b0, e}) begin bad++; $display("FAIL ovr_byte: got %h exp %h", v, e); end
    end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL ovr_irq: got %b exp 0", irq); end
    send_rx(8'h99, 1'b0);
    set_addr(BASE + 32'h1004);
    total++; if (rdata !== 32'h14) begin bad++; $display("FAIL ferr_status: got %h exp 14", rdata); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL ferr_irq: got %b exp 1", irq); end
    read(v);
    total++; if (rdata !== 32'h4) begin bad++; $display("FAIL ferr_clear: got %h exp 4", rdata); end
    uart_rxd = 1'b0;
    repeat (20) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    total++; if (rdata !== 32'h4) begin bad++; $display("FAIL glitch_status: got %h exp 4", rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL glitch_irq: got %b exp 0", irq); end
  endtask

  task automatic test_timer();
    logic [31:0] t1;
    set_addr(BASE + 32'h2000);
    t1 = rdata;
    @(negedge clk);
    total++; if (rdata !== t1 + 32'd1) begin bad++; $display("FAIL timer_inc: got %h exp %h", rdata, t1 + 32'd1); end
    store(32'hFFFF_FFFE);
    total++; if (rdata !== 32'hFFFF_FFFE) begin bad++; $display("FAIL timer_load: got %h exp fffffffe", rdata); end
    @(negedge clk);
    total++; if (rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timer_max: got %h exp ffffffff", rdata); end
    @(negedge clk);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL timer_wrap: got %h exp 0", rdata); end
  endtask

  task automatic test_reset_mid_tx();
    set_addr(BASE + 32'h1000);
    store(32'h81);
    store(32'h42);
    repeat (3 * DIV) @(negedge clk);
    total++; if (uart_txd !== 1'b0) begin bad++; $display("FAIL midtx_busy: txd got %b exp 0", uart_txd); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL midtx_txd: got %b exp 1", uart_txd); end
    total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL midtx_gpio: got %h exp 00", gpio_out); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL midtx_rdata: got %h exp 0", rdata); end
    rst = 1'b0;
    set_addr(BASE + 32'h1004);
    total++; if (rdata !== 32'h4) begin bad++; $display("FAIL midtx_status: got %h exp 4", rdata); end
    repeat (12 * DIV) @(negedge clk);
    got_tx.delete(); got_t.delete();
    repeat (12 * DIV) @(negedge clk);
    total++; if (got_tx.size() != 0) begin bad++; $display("FAIL midtx_frames: got %0d exp 0", got_tx.size()); end
    total++; if (rdata !== 32'h4) begin bad++; $display("FAIL midtx_idle: got %h exp 4", rdata); end
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_back_to_back();
    test_tx_full();
    test_rx_single();
    test_rx_errors();
    test_timer();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
